// File: rtl/sprite_frame_sel.sv
// -----------------------------------------------------------------------------
// sprite_frame_sel
//
// Purpose
//   Picks the sprite animation frame for a single character and outputs one
//   pixel from that frame. Each facing (front or back) has F = 2 + WALK_N
//   frames, numbered:
//     0        stand
//     1        jump
//     2..F-1   walk0 .. walk(WALK_N-1)
//   The back-facing frames sit above the front-facing ones, so
//   frame_sel = facing * F + local index.
//   The animation state changes only on "update edges". An update edge is a
//   clk25 edge where frame_tick = 1 and pause = 0. The sprite therefore never
//   switches frames partway through a video frame.
//
// Ports
//   clk25       in   pixel clock (single clock domain)
//   rst         in   asynchronous active-high reset
//   frame_tick  in   one-cycle pulse, once per video frame
//   pause       in   freezes the animation state while high
//   moving      in   walking request
//   jump_act    in   airborne request (takes priority over moving)
//   facing      in   0 = front, 1 = back
//   pix_in      in   NF*PIX_W; frame k pixel is at [k*PIX_W +: PIX_W]
//   pix_out     out  selected pixel, registered, one cycle behind pix_in
//   pix_opaque  out  registered, 1 when pix_out != TRANSP
//   frame_sel   out  current frame index, registered
//   anim_state  out  FSM state: 0 STAND, 1 WALK, 2 JUMP (debug view of the FSM)
//
// Signal qualification
//   There is no valid/ready handshake. frame_tick is the only qualifier.
//   moving, jump_act and facing are sampled only on update edges. Between
//   update edges these inputs have no effect.
// -----------------------------------------------------------------------------
module sprite_frame_sel #(
    parameter int              PIX_W    = 8,
    parameter int              WALK_N   = 2,
    parameter int              ANIM_DIV = 6,
    parameter logic [PIX_W-1:0] TRANSP  = '0,
    localparam int             F        = 2 + WALK_N,
    localparam int             NF       = 2 * F,
    localparam int             FS_W     = $clog2(NF)
) (
    input  logic                clk25,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                pause,
    input  logic                moving,
    input  logic                jump_act,
    input  logic                facing,
    input  logic [NF*PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0]    pix_out,
    output logic                pix_opaque,
    output logic [FS_W-1:0]     frame_sel,
    output logic [1:0]          anim_state
);

    // Counter widths never drop below 1 bit. With ANIM_DIV = 1 or
    // WALK_N = 1 the counter compares against 0 and therefore behaves
    // correctly.
    localparam int TICK_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int WIDX_W = (WALK_N > 1) ? $clog2(WALK_N) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ANIM_DIV - 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WALK_N - 1);
    localparam logic [FS_W-1:0]   BACK_OFS  = FS_W'(F);
    localparam logic [FS_W-1:0]   LOC_JUMP  = FS_W'(1);
    localparam logic [FS_W-1:0]   LOC_WALK0 = FS_W'(2);

    typedef enum logic [1:0] {
        ST_STAND = 2'd0,
        ST_WALK  = 2'd1,
        ST_JUMP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_nxt;
    logic [WIDX_W-1:0]   walk_idx;
    logic [WIDX_W-1:0]   widx_nxt;
    logic [FS_W-1:0]     local_nxt;
    logic [FS_W-1:0]     frame_nxt;
    logic [PIX_W-1:0]    sel_pix;
    logic                upd;

    // A tick that arrives during pause is dropped. It is not saved for later.
    assign upd = frame_tick & ~pause;

    // ------------------------------------------------------------------
    // Next-state decision. The same rule applies from every state:
    // jump_act wins over moving.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = ST_STAND;
        if (jump_act) begin
            state_nxt = ST_JUMP;
        end else if (moving) begin
            state_nxt = ST_WALK;
        end
    end

    // ------------------------------------------------------------------
    // Walk counters. They advance only while the FSM stays in WALK.
    // Entering WALK from another state starts at walk0 with tick_cnt = 0.
    // In STAND and JUMP both counters are forced to zero.
    // ------------------------------------------------------------------
    always_comb begin
        tick_nxt = '0;
        widx_nxt = '0;
        if ((state_nxt == ST_WALK) && (state == ST_WALK)) begin
            if (tick_cnt == TICK_LAST) begin
                tick_nxt = '0;
                if (walk_idx == WIDX_LAST) begin
                    widx_nxt = '0;
                end else begin
                    widx_nxt = walk_idx + WIDX_W'(1);
                end
            end else begin
                tick_nxt = tick_cnt + TICK_W'(1);
                widx_nxt = walk_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame index for the next update. The latched facing is not stored
    // in a separate register. frame_sel already records it: frames at or
    // above F are back-facing.
    // ------------------------------------------------------------------
    always_comb begin
        case (state_nxt)
            ST_JUMP: local_nxt = LOC_JUMP;
            ST_WALK: local_nxt = LOC_WALK0 + FS_W'(widx_nxt);
            default: local_nxt = '0;
        endcase
        frame_nxt = facing ? (BACK_OFS + local_nxt) : local_nxt;
    end

    // ------------------------------------------------------------------
    // Animation registers. All of them move together on an update edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state     <= ST_STAND;
            tick_cnt  <= '0;
            walk_idx  <= '0;
            frame_sel <= '0;
        end else if (upd) begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            walk_idx  <= widx_nxt;
            frame_sel <= frame_nxt;
        end
    end

    assign anim_state = state;

    // ------------------------------------------------------------------
    // Pixel path. Each frame slice is compared against the registered
    // frame_sel, which keeps the mux free of any out-of-range index.
    // pix_out updates on every edge, including while paused.
    // ------------------------------------------------------------------
    always_comb begin
        sel_pix = '0;
        for (int k = 0; k < NF; k++) begin
            if (frame_sel == FS_W'(k)) begin
                sel_pix = pix_in[k*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            pix_out    <= '0;
            pix_opaque <= 1'b0;
        end else begin
            pix_out    <= sel_pix;
            pix_opaque <= (sel_pix != TRANSP);
        end
    end

endmodule

// File: tb/tb_sprite_frame_sel.sv
// -----------------------------------------------------------------------------
// tb_sprite_frame_sel
//
// Testbench for sprite_frame_sel with the default parameters.
// The expected outputs come from a reference model that counts how many
// update edges the sprite has spent walking. walk_idx is then
// (walk_ticks / ANIM_DIV) % WALK_N. A queue holds the expected pixel
// stream. Directed steps with hand-computed values pin the reference
// model itself, and a randomized run follows them.
// -----------------------------------------------------------------------------
module tb_sprite_frame_sel;

    localparam int PIX_W    = 8;
    localparam int WALK_N   = 2;
    localparam int ANIM_DIV = 6;
    localparam int F        = 2 + WALK_N;
    localparam int NF       = 2 * F;
    localparam int FS_W     = $clog2(NF);
    localparam logic [PIX_W-1:0] TRANSP = 8'h00;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                frame_tick = 1'b0;
    logic                pause      = 1'b0;
    logic                moving     = 1'b0;
    logic                jump_act   = 1'b0;
    logic                facing     = 1'b0;
    logic [NF*PIX_W-1:0] pix_in;
    logic [PIX_W-1:0]    pix_out;
    logic                pix_opaque;
    logic [FS_W-1:0]     frame_sel;
    logic [1:0]          anim_state;

    sprite_frame_sel #(
        .PIX_W   (PIX_W),
        .WALK_N  (WALK_N),
        .ANIM_DIV(ANIM_DIV),
        .TRANSP  (TRANSP)
    ) dut (
        .clk25     (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .pause     (pause),
        .moving    (moving),
        .jump_act  (jump_act),
        .facing    (facing),
        .pix_in    (pix_in),
        .pix_out   (pix_out),
        .pix_opaque(pix_opaque),
        .frame_sel (frame_sel),
        .anim_state(anim_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state      = 0;   // 0 stand, 1 walk, 2 jump
    int m_face       = 0;
    int m_walk_ticks = 0;   // update edges spent in WALK since it was entered
    int m_frame      = 0;
    logic [PIX_W:0] exp_q[$];
    logic [PIX_W:0] exp_word = '0;

    always @(posedge clk or posedge rst) begin
        int ns;
        logic [PIX_W-1:0] pv;
        if (rst) begin
            m_state = 0; m_face = 0; m_walk_ticks = 0; m_frame = 0;
            exp_q.delete();
        end else begin
            pv = pix_in[m_frame*PIX_W +: PIX_W];
            exp_q.push_back({pv != TRANSP, pv});
            if (frame_tick && !pause) begin
                ns = jump_act ? 2 : (moving ? 1 : 0);
                if (ns == 1 && m_state == 1) m_walk_ticks++;
                else m_walk_ticks = 0;
                m_state = ns;
                m_face  = facing ? 1 : 0;
                m_frame = m_face * F + ((ns == 0) ? 0 : (ns == 2) ? 1 :
                          2 + (m_walk_ticks / ANIM_DIV) % WALK_N);
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst) exp_word = '0;
            else if (exp_q.size() > 0) exp_word = exp_q.pop_front();
            check("sb_frame_sel",  frame_sel,  m_frame);
            check("sb_anim_state", anim_state, m_state);
            check("sb_pix_out",    pix_out,    exp_word[PIX_W-1:0]);
            check("sb_pix_opaque", pix_opaque, exp_word[PIX_W]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic mv, input logic jp, input logic fc, input logic ps);
        @(posedge clk); #2;
        moving = mv; jump_act = jp; facing = fc; pause = ps; frame_tick = 1'b1;
        @(posedge clk); #2;
        frame_tick = 1'b0; pause = 1'b0;
    endtask

    task automatic load_default_pix();
        for (int k = 0; k < NF; k++) pix_in[k*PIX_W +: PIX_W] = PIX_W'(k + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_f;
        load_default_pix();
        repeat (3) @(negedge clk);
        check("rst_frame_sel",  frame_sel,  0);
        check("rst_anim_state", anim_state, 0);
        check("rst_pix_out",    pix_out,    0);
        check("rst_pix_opaque", pix_opaque, 0);
        @(posedge clk); #2; rst = 1'b0;

        // stand tick, front facing
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stand_frame", frame_sel, 0);
        check("stand_state", anim_state, 0);
        @(negedge clk);
        check("stand_pix", pix_out, 8'h01);

        // walk back-facing, 13 ticks with irregular gaps
        for (int i = 0; i < 13; i++) begin
            pulse(1'b1, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            exp_f = (i < 6) ? 6 : (i < 12) ? 7 : 6;
            check("walk_seq", frame_sel, exp_f);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // jump wins over moving, then back to WALK at walk0
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("jump_state", anim_state, 2);
        check("jump_frame", frame_sel, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rewalk_state", anim_state, 1);
        check("rewalk_frame", frame_sel, 2);

        // facing change between ticks is ignored
        @(posedge clk); #2; facing = 1'b1;
        repeat (3) @(negedge clk);
        check("facing_hold", frame_sel, 2);
        // paused tick is discarded
        pulse(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("pause_frame", frame_sel, 2);
        check("pause_state", anim_state, 1);
        // pixel path still tracks pix_in
        @(posedge clk); #2; pix_in[2*PIX_W +: PIX_W] = 8'h5A;
        repeat (2) @(negedge clk);
        check("pause_pix", pix_out, 8'h5A);

        // transparency flag
        @(posedge clk); #2; pix_in[2*PIX_W +: PIX_W] = 8'h00;
        repeat (2) @(negedge clk);
        check("transp_flag", pix_opaque, 0);
        @(posedge clk); #2; pix_in[2*PIX_W +: PIX_W] = 8'h05;
        repeat (2) @(negedge clk);
        check("opaque_flag", pix_opaque, 1);
        check("opaque_pix",  pix_out, 8'h05);

        // reset mid-walk: advance into walk1 first
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_frame", frame_sel, 3);
        @(posedge clk); #2; rst = 1'b1;
        @(negedge clk);
        check("mid_rst_frame",  frame_sel,  0);
        check("mid_rst_state",  anim_state, 0);
        check("mid_rst_pix",    pix_out,    0);
        check("mid_rst_opaque", pix_opaque, 0);
        @(posedge clk); #2; rst = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_walk", frame_sel, 2);

        // randomized run against the reference model
        load_default_pix();
        for (int c = 0; c < 4000; c++) begin
            int k;
            @(posedge clk); #2;
            rst        = ($urandom_range(0, 399) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            pause      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) moving   = ~moving;
            if ($urandom_range(0, 19) == 0) jump_act = ~jump_act;
            if ($urandom_range(0, 9)  == 0) facing   = ~facing;
            if ($urandom_range(0, 3)  == 0) begin
                k = $urandom_range(0, NF - 1);
                pix_in[k*PIX_W +: PIX_W] = ($urandom_range(0, 2) == 0) ? TRANSP
                                           : PIX_W'($urandom_range(0, 255));
            end
        end
        @(posedge clk); #2;
        rst = 1'b0; frame_tick = 1'b0; pause = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_frame_sel.md
SPRITE_FRAME_SEL -- requirements
Module: sprite_frame_sel

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning pixel/colour width in bits.
REQ-002 The block SHALL have parameter WALK_N, default 2 (range 1..8), meaning walk frames per facing.
REQ-003 The block SHALL have parameter ANIM_DIV, default 6 (range 1..255), meaning frame ticks per walk frame.
REQ-004 The block SHALL have parameter TRANSP, default 8'h00 (PIX_W wide), meaning transparent colour code.
REQ-005 The block SHALL derive F = 2+WALK_N frames per facing and NF = 2*F total frames.
REQ-006 The block SHALL have port clk25, input, 1, meaning pixel clock; single clock domain.
REQ-007 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-008 The block SHALL have port frame_tick, input, 1, meaning one-cycle pulse once per video frame.
REQ-009 The block SHALL have port pause, input, 1, meaning freeze animation state when high.
REQ-010 The block SHALL have port moving, input, 1, meaning character walking request.
REQ-011 The block SHALL have port jump_act, input, 1, meaning character airborne request.
REQ-012 The block SHALL have port facing, input, 1, meaning 0 = front, 1 = back.
REQ-013 The block SHALL have port pix_in, input, NF*PIX_W, meaning frame k pixel at bits [k*PIX_W +: PIX_W].
REQ-014 The block SHALL have port pix_out, output, PIX_W, meaning selected pixel, registered.
REQ-015 The block SHALL have port pix_opaque, output, 1, meaning registered flag, 1 when pix_out != TRANSP.
REQ-016 The block SHALL have port frame_sel, output, clog2(NF), meaning current frame index.
REQ-017 The block SHALL have port anim_state, output, 2, meaning 0 STAND, 1 WALK, 2 JUMP.

Function
REQ-018 The block SHALL number frames within a facing as: 0 stand, 1 jump, 2..F-1 walk0..walk(WALK_N-1).
REQ-019 The block SHALL set frame_sel = facing_q*F + local index, where facing_q is the latched facing.
REQ-020 The block SHALL update anim_state, facing_q and animation counters only on clk25 edges where frame_tick=1 and pause=0 (no mid-frame tearing).
REQ-021 On an update edge the FSM SHALL go to JUMP if jump_act=1, else WALK if moving=1, else STAND, from any state (jump_act has priority over moving).
REQ-022 On an update edge facing_q SHALL load facing.
REQ-023 The block SHALL keep tick_cnt (0..ANIM_DIV-1) and walk_idx (0..WALK_N-1) counters.
REQ-024 On an update edge entering WALK from STAND or JUMP, tick_cnt and walk_idx SHALL clear to 0.
REQ-025 On an update edge remaining in WALK, tick_cnt SHALL increment; at ANIM_DIV-1 it SHALL wrap to 0 and walk_idx SHALL advance, wrapping WALK_N-1 to 0.
REQ-026 With ANIM_DIV=1, walk_idx SHALL advance on every update edge in WALK.
REQ-027 With WALK_N=1, walk_idx SHALL stay 0.
REQ-028 In STAND and JUMP, tick_cnt and walk_idx SHALL be held at 0.
REQ-029 The local index SHALL be 0 in STAND, 1 in JUMP, and 2+walk_idx in WALK.
REQ-030 frame_sel and anim_state SHALL be registered and change on the same edge as the FSM update.
REQ-031 Every clk25 edge, pix_out SHALL load pix_in slice frame_sel and pix_opaque SHALL load (that slice != TRANSP): one-cycle latency from pix_in, independent of pause.
REQ-032 When frame_tick=1 and pause=1 on the same edge, the tick SHALL be discarded and not deferred.
REQ-033 Inputs moving, jump_act and facing SHALL be ignored between update edges.

Reset
REQ-034 While rst=1, outputs SHALL be held at: anim_state=STAND, facing_q=0, tick_cnt=0, walk_idx=0, frame_sel=0, pix_out=0, pix_opaque=0.
REQ-035 The first update edge after rst deasserts SHALL follow REQ-021 normally.
REQ-036 Asserting rst mid-walk SHALL abort the walk immediately; WALK re-entry SHALL start at walk0.

Verification (defaults PIX_W=8, WALK_N=2, ANIM_DIV=6; pix_in frame k = k+1)
REQ-037 Reset, then frame_tick with moving=0, jump_act=0, facing=0 -> frame_sel=0; pix_out=1 one cycle later.
REQ-038 moving=1, facing=1, 13 frame_ticks -> frame_sel sequence 6 (x6), 7 (x6), then 6.
REQ-039 moving=1 and jump_act=1 with the same tick -> anim_state=2, frame_sel=1; deassert jump_act, next tick -> WALK, frame_sel=2.
REQ-040 facing toggled between ticks -> frame_sel unchanged until the next tick; pause=1 with tick -> no change, and pix_out still tracks pix_in.
REQ-041 pix_in slice set to 8'h00 -> pix_opaque=0; set to 8'h05 -> pix_opaque=1; rst pulse mid-walk -> all outputs 0, next WALK tick -> frame_sel=2.
